// File: rtl/ifetch_stage.sv
// Fetch stage: owns the PC, issues credit-limited word requests to instruction memory,
// buffers in-order responses and presents InstrF/PCPlus8 to decode; redirect flushes everything.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus8,
  output logic        ValidF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_iss_rd;
  logic [AW-1:0] r_iss_wr;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_bpc   [DEPTH];
  logic [31:0]   r_iss_pc[DEPTH];

  logic [CW:0]   w_used;
  logic          w_grant;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_target;

  assign w_used   = {1'b0, r_outstanding} + {1'b0, r_count};
  assign imem_req = !reset && !PCSrc && (w_used < (CW+1)'(DEPTH));
  assign imem_addr = r_pc & ~32'h3;
  assign w_target  = PCTarget & ~32'h3;

  assign w_grant = imem_req && imem_gnt;
  assign w_drop  = imem_rvalid && (r_discard != '0);
  assign w_push  = imem_rvalid && !w_drop && !PCSrc;
  assign w_pop   = ValidF && !stall && !PCSrc;

  assign ValidF  = (r_count != '0);
  assign InstrF  = ValidF ? r_instr[r_rd_ptr] : NOP_INSTR;
  assign PCPlus8 = ValidF ? (r_bpc[r_rd_ptr] + 32'd8) : (r_pc + 32'd8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_iss_rd      <= '0;
      r_iss_wr      <= '0;
    end else begin
      // Issued-PC FIFO tracks every request, stale or not, so it stays aligned with responses.
      if (w_grant) begin
        r_iss_wr <= r_iss_wr + 1'b1;
        r_pc     <= r_pc + 32'd4;
      end
      if (imem_rvalid) r_iss_rd <= r_iss_rd + 1'b1;
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem_rvalid);

      if (PCSrc) begin
        r_pc      <= w_target;
        r_count   <= '0;
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
        r_discard <= r_outstanding - CW'(imem_rvalid);
      end else begin
        if (w_drop) r_discard <= r_discard - 1'b1;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_iss_pc[r_iss_wr] <= r_pc;
    if (w_push) begin
      r_instr[r_wr_ptr] <= imem_rdata;
      r_bpc[r_wr_ptr]   <= r_iss_pc[r_iss_rd];
    end
  end

endmodule
